rf_port_arbiter: RTL

//  Shares the single register-file access slot (two read ports plus one write port per cycle) among NREQ requesters.

---
 rtl/rf_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 70 +++++++
 rtl/rf_port_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file port arbiter.
//   RF_ADDR_W / RF_DATA_W : default register address / data widths
//   rf_beat_t             : one requester beat (optional write plus two reads)
// -----------------------------------------------------------------------------
package rf_arb_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   typedef struct packed {
      logic                 we;
      logic [RF_ADDR_W-1:0] rs;
      logic [RF_ADDR_W-1:0] rt;
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] wdata;
   } rf_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk      in   clock, posedge
//   rst      in   synchronous active-high reset (pointer -> 0)
//   req      in   N request lines
//   advance  in   the current winner is consumed; move pointer past it
//   gnt      out  one-hot grant (zero when no request)
//   gnt_idx  out  binary index of the winner (valid when gnt != 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N     = 3,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W:0]   cand;
   logic             found;

   // Scan from the pointer upward, wrapping modulo N; the first requester
   // seen wins. cand has one spare bit so ptr+k never overflows before wrap.
   always_comb begin
      gnt     = '0;
      gnt_idx = ptr_q;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) begin
            cand = cand - (IDX_W+1)'(N);
         end
         if (!found && req[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
         end
      end
      if (found) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // Winner drops to lowest priority; with no grant the pointer holds.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         if (gnt_idx == IDX_W'(N-1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_port_arbiter.sv
// -----------------------------------------------------------------------------
// rf_port_arbiter
// Shares one register-file access slot (2 reads + 1 write per cycle) among
// NREQ requesters using round-robin grants. Read data comes back one cycle
// after the grant on a shared bus, tagged by a one-hot rsp_valid.
//   clk, rst                 clock / synchronous active-high reset
//   req_valid/req_ready      per-requester one-beat handshake (ready one-hot)
//   req_we/rs/rt/rd/wdata    per-requester beat payload, packed slices
//   rsp_valid                one-hot response strobe, one cycle after accept
//   rsp_rs_data/rsp_rt_data  read data returned for the responding requester
//   rf_we/rf_*_addr/rf_rd_data  drive the register file
//   rf_rs_data/rf_rt_data    register-file read data (registered, 1 cycle)
// -----------------------------------------------------------------------------
module rf_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_rs,
   input  logic [NREQ*ADDR_W-1:0] req_rt,
   input  logic [NREQ*ADDR_W-1:0] req_rd,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rs_data,
   output logic [DATA_W-1:0]      rsp_rt_data,
   output logic                   rf_we,
   output logic [ADDR_W-1:0]      rf_rs_addr,
   output logic [ADDR_W-1:0]      rf_rt_addr,
   output logic [ADDR_W-1:0]      rf_rd_addr,
   output logic [DATA_W-1:0]      rf_rd_data,
   input  logic [DATA_W-1:0]      rf_rs_data,
   input  logic [DATA_W-1:0]      rf_rt_data
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   arb_req;
   logic [NREQ-1:0]   gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              any_gnt;
   logic [NREQ-1:0]   tag_q;
   logic [NREQ-1:0]   tag_d;

   logic [ADDR_W-1:0] rs_arr    [NREQ];
   logic [ADDR_W-1:0] rt_arr    [NREQ];
   logic [ADDR_W-1:0] rd_arr    [NREQ];
   logic [DATA_W-1:0] wdata_arr [NREQ];

   // Unpack the flat slice buses so the winner can be selected by index.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign rs_arr[gi]    = req_rs[gi*ADDR_W +: ADDR_W];
         assign rt_arr[gi]    = req_rt[gi*ADDR_W +: ADDR_W];
         assign rd_arr[gi]    = req_rd[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Nothing is granted while reset is held, even if requesters are valid.
   assign arb_req = rst ? '0 : req_valid;

   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req),
      .advance (any_gnt),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign any_gnt   = |gnt;
   assign req_ready = gnt;

   // Payload of the winner goes straight to the register file. No bypass:
   // a same-beat read of the written address returns the old contents.
   assign rf_we      = any_gnt & req_we[gnt_idx];
   assign rf_rs_addr = rs_arr[gnt_idx];
   assign rf_rt_addr = rt_arr[gnt_idx];
   assign rf_rd_addr = rd_arr[gnt_idx];
   assign rf_rd_data = wdata_arr[gnt_idx];

   // One-hot tag of the beat accepted last cycle; its read data arrives now.
   assign tag_d = gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   // Masking with rst drops the response of a beat granted just before reset.
   assign rsp_valid   = rst ? '0 : tag_q;
   assign rsp_rs_data = rf_rs_data;
   assign rsp_rt_data = rf_rt_data;

endmodule
